// File: rtl/io_pkg.sv
// -----------------------------------------------------------------------------
// io_pkg
//   Shared constants and types for the core's I/O-side peripherals.
//   IO_SW_W      : width of the switch word presented to the core.
//   TICK_DIV_DEF : default clocks per debounce sample tick (1 ms at 50 MHz).
//   DB_TICKS_DEF : default number of consecutive differing ticks to accept a change.
//   io_word_t    : one core-visible I/O word.
// -----------------------------------------------------------------------------
package io_pkg;

  localparam int IO_SW_W      = 32;
  localparam int TICK_DIV_DEF = 50000;
  localparam int DB_TICKS_DEF = 16;

  typedef logic [IO_SW_W-1:0] io_word_t;

endpackage : io_pkg

// File: rtl/sw_debounce_bit.sv
// -----------------------------------------------------------------------------
// sw_debounce_bit
//   One switch bit: two-flop synchroniser, run-length counter and accepted
//   (stable) level. The counter only advances on sample ticks supplied by the
//   parent, so the debounce window is DB_TICKS ticks long.
//
//   Optional build macro IO_SW_DB_BYPASS_EN: no counter; the stable flop simply
//   follows the synchronised level every clock and i_tick is ignored.
//
// Ports
//   i_clk      system clock
//   i_reset_n  asynchronous active-low reset
//   i_raw      raw switch pin (asynchronous to i_clk)
//   i_tick     one-cycle sample-tick strobe
//   o_stable   accepted (debounced) level, a register
//   o_upd      high in the cycle whose closing edge changes o_stable
// -----------------------------------------------------------------------------
module sw_debounce_bit #(
  parameter int DB_TICKS = 16
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_raw,
  input  logic i_tick,
  output logic o_stable,
  output logic o_upd
);

  logic sync1_q;
  logic sync2_q;
  logic stable_q;
  logic stable_d;
  logic upd_s;

  // Two-flop synchroniser; nothing may read the first stage.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= i_raw;
      sync2_q <= sync1_q;
    end
  end

`ifdef IO_SW_DB_BYPASS_EN

  logic tick_unused_s;
  assign tick_unused_s = i_tick;

  // Bypass: accept the synchronised level immediately.
  always_comb begin
    stable_d = sync2_q;
    upd_s    = sync2_q ^ stable_q;
  end

  // Accepted-level register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      stable_q <= 1'b0;
    end else begin
      stable_q <= stable_d;
    end
  end

`else

  localparam int              CNT_W   = $clog2(DB_TICKS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_TICKS - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Counter runs while the sample differs from the accepted level; any equal
  // sample restarts it, and reaching CNT_MAX on a differing sample accepts.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    upd_s    = 1'b0;
    if (i_tick) begin
      if (sync2_q == stable_q) begin
        cnt_d = {CNT_W{1'b0}};
      end else if (cnt_q == CNT_MAX) begin
        stable_d = sync2_q;
        cnt_d    = {CNT_W{1'b0}};
        upd_s    = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter and accepted-level registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q    <= {CNT_W{1'b0}};
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

`endif

  assign o_stable = stable_q;
  assign o_upd    = upd_s;

endmodule : sw_debounce_bit

// File: rtl/io_sw_debounce.sv
// -----------------------------------------------------------------------------
// io_sw_debounce
//   Switch-port peripheral for the single-cycle core. Synchronises and
//   debounces N_SW raw board switches, presents them zero-extended as a 32-bit
//   word, and keeps sticky per-bit change flags with a masked clear strobe.
//
//   Optional build macro IO_SW_DB_BYPASS_EN: prescaler and debounce counters
//   are not built, the debounced word follows the synchronised pins with three
//   cycles of latency, and o_tick is tied low. Intended for fast simulation.
//
// Ports
//   i_clk           system clock
//   i_reset_n       asynchronous active-low reset
//   i_sw            raw switch pins (asynchronous)
//   i_evt_clr       one-cycle strobe clearing the flags selected by the mask
//   i_evt_clr_mask  per-bit clear select, ignored while i_evt_clr is low
//   o_io_sw         {zeros, debounced state} for the core's switch input
//   o_sw_event      sticky flag per bit, set when the debounced bit changes
//   o_irq           registered OR of o_sw_event
//   o_tick          registered one-cycle sample-tick pulse (debug)
// -----------------------------------------------------------------------------
module io_sw_debounce
  import io_pkg::*;
#(
  parameter int N_SW     = 17,
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int DB_TICKS = DB_TICKS_DEF
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic [N_SW-1:0] i_sw,
  input  logic            i_evt_clr,
  input  logic [N_SW-1:0] i_evt_clr_mask,
  output io_word_t        o_io_sw,
  output logic [N_SW-1:0] o_sw_event,
  output logic            o_irq,
  output logic            o_tick
);

  logic            tick_s;
  logic [N_SW-1:0] stable_s;
  logic [N_SW-1:0] upd_s;
  logic [N_SW-1:0] set_s;
  logic [N_SW-1:0] clr_s;
  logic [N_SW-1:0] evt_q;
  logic [N_SW-1:0] evt_d;
  logic            irq_q;
  io_word_t        io_d;

  for (genvar k = 0; k < N_SW; k++) begin : g_bit
    sw_debounce_bit #(
      .DB_TICKS (DB_TICKS)
    ) u_bit (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_raw     (i_sw[k]),
      .i_tick    (tick_s),
      .o_stable  (stable_s[k]),
      .o_upd     (upd_s[k])
    );
  end

  // Zero-extend the debounced bits to the core word.
  always_comb begin
    io_d             = '0;
    io_d[N_SW-1:0]   = stable_s;
  end

`ifdef IO_SW_DB_BYPASS_EN

  assign tick_s  = 1'b0;
  assign o_tick  = 1'b0;
  // The stable flops are already the third register stage, so they drive the
  // port directly and events set on the same edge the word changes.
  assign o_io_sw = io_d;
  assign set_s   = upd_s;

`else

  localparam int               PRE_W   = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_d;
  logic             tick_q;
  logic [N_SW-1:0]  upd_q;
  io_word_t         io_q;

  // Sample-tick prescaler, wrapping at TICK_DIV-1.
  always_comb begin
    tick_s = (pre_q == PRE_MAX);
    if (tick_s) begin
      pre_d = {PRE_W{1'b0}};
    end else begin
      pre_d = pre_q + PRE_W'(1);
    end
  end

  // Prescaler, tick output and output word registers. upd_q delays the change
  // strobe so the event flag rises together with the updated o_io_sw.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pre_q  <= {PRE_W{1'b0}};
      tick_q <= 1'b0;
      upd_q  <= {N_SW{1'b0}};
      io_q   <= '0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_s;
      upd_q  <= upd_s;
      io_q   <= io_d;
    end
  end

  assign o_tick  = tick_q;
  assign o_io_sw = io_q;
  assign set_s   = upd_q;

`endif

  // Sticky event flags: masked clear, with a same-cycle set taking priority.
  always_comb begin
    if (i_evt_clr) begin
      clr_s = i_evt_clr_mask;
    end else begin
      clr_s = {N_SW{1'b0}};
    end
    evt_d = (evt_q & ~clr_s) | set_s;
  end

  // Event flags and interrupt register (irq trails the flags by one cycle).
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      evt_q <= {N_SW{1'b0}};
      irq_q <= 1'b0;
    end else begin
      evt_q <= evt_d;
      irq_q <= |evt_q;
    end
  end

  assign o_sw_event = evt_q;
  assign o_irq      = irq_q;

endmodule : io_sw_debounce
